// File: rtl/tt_frame_feeder.sv
// tt_frame_feeder: buffers one frame of 4-bit node pairs (query first, then edges)
// from a bursty valid/ready source and replays it to the shortest-path engine as a
// single gap-free in_valid burst, then captures the engine result under a watchdog.
// Ports: up_* upstream pair stream; tt_* engine burst and result; res_* result report.
// Latency: burst starts the cycle after up_last is accepted; result one cycle after
// out_valid. up_ready is low from the burst until the cycle after the result strobe.
module tt_frame_feeder #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_valid,
  output logic       up_ready,
  input  logic [3:0] up_src,
  input  logic [3:0] up_dst,
  input  logic       up_last,
  output logic       tt_in_valid,
  output logic [3:0] tt_source,
  output logic [3:0] tt_destination,
  input  logic       tt_out_valid,
  input  logic [3:0] tt_cost,
  output logic       res_valid,
  output logic [3:0] res_cost,
  output logic       res_overflow,
  output logic       res_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {COLLECT, EMIT, WAIT, REPORT} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          ovf;
  logic [TW-1:0] wait_cnt;

  logic          hs;
  logic          full;
  logic          last_emit;
  logic          expire;

  logic          up_ready_nx;
  logic          tt_in_valid_nx;
  logic [7:0]    tt_pair_nx;
  logic          res_valid_nx;
  logic [3:0]    res_cost_nx;
  logic          res_overflow_nx;
  logic          res_timeout_nx;

  assign hs        = up_valid && up_ready;
  assign full      = (count == CW'(DEPTH));
  assign last_emit = ({1'b0, rd_ptr} == (count - CW'(1)));
  assign expire    = (wait_cnt == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (hs && up_last)              state_nx = EMIT;
      EMIT:    if (last_emit)                  state_nx = WAIT;
      WAIT:    if (tt_out_valid || expire)     state_nx = REPORT;
      REPORT:                                  state_nx = COLLECT;
      default:                                 state_nx = COLLECT;
    endcase
  end

  // Output decode: every output is registered, so values are derived from the
  // state being entered rather than the current one.
  always_comb begin
    up_ready_nx     = (state_nx == COLLECT);
    tt_in_valid_nx  = (state_nx == EMIT);
    tt_pair_nx      = 8'h00;
    res_valid_nx    = (state_nx == REPORT);
    res_cost_nx     = 4'd0;
    res_overflow_nx = 1'b0;
    res_timeout_nx  = 1'b0;
    if (state_nx == EMIT) begin
      if (state == COLLECT) begin
        // Query-only frame: entry 0 is being written this very cycle, bypass it.
        tt_pair_nx = (count == CW'(0)) ? {up_src, up_dst} : mem[0];
      end else begin
        tt_pair_nx = mem[rd_ptr + AW'(1)];
      end
    end
    if ((state == WAIT) && (state_nx == REPORT)) begin
      // A result arriving in the expiry cycle takes priority over the timeout.
      res_cost_nx     = tt_out_valid ? tt_cost : 4'd0;
      res_timeout_nx  = !tt_out_valid;
      res_overflow_nx = ovf;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_ready       <= 1'b1;
      tt_in_valid    <= 1'b0;
      tt_source      <= 4'd0;
      tt_destination <= 4'd0;
      res_valid      <= 1'b0;
      res_cost       <= 4'd0;
      res_overflow   <= 1'b0;
      res_timeout    <= 1'b0;
    end else begin
      up_ready       <= up_ready_nx;
      tt_in_valid    <= tt_in_valid_nx;
      tt_source      <= tt_pair_nx[7:4];
      tt_destination <= tt_pair_nx[3:0];
      res_valid      <= res_valid_nx;
      res_cost       <= res_cost_nx;
      res_overflow   <= res_overflow_nx;
      res_timeout    <= res_timeout_nx;
    end
  end

  // Frame bookkeeping: fill level, read pointer, overflow flag, watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        COLLECT: begin
          rd_ptr   <= '0;
          wait_cnt <= '0;
          if (hs) begin
            if (full) begin
              ovf <= 1'b1;
            end else begin
              count  <= count + CW'(1);
              wr_ptr <= wr_ptr + AW'(1);
            end
          end
        end
        EMIT:   rd_ptr   <= rd_ptr + AW'(1);
        WAIT:   wait_cnt <= wait_cnt + TW'(1);
        REPORT: begin
          count    <= '0;
          wr_ptr   <= '0;
          ovf      <= 1'b0;
          wait_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Frame storage; pairs beyond DEPTH are dropped
  always_ff @(posedge clk) begin
    if (hs && !full) mem[wr_ptr] <= {up_src, up_dst};
  end

endmodule

// File: tb/tb_tt_frame_feeder.sv
module tb_tt_frame_feeder;

  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_valid = 1'b0;
  logic       up_ready;
  logic [3:0] up_src = 4'd0;
  logic [3:0] up_dst = 4'd0;
  logic       up_last = 1'b0;
  logic       tt_in_valid;
  logic [3:0] tt_source;
  logic [3:0] tt_destination;
  logic       tt_out_valid = 1'b0;
  logic [3:0] tt_cost = 4'd0;
  logic       res_valid;
  logic [3:0] res_cost;
  logic       res_overflow;
  logic       res_timeout;

  always #5 clk = ~clk;

  tt_frame_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .up_valid       (up_valid),
    .up_ready       (up_ready),
    .up_src         (up_src),
    .up_dst         (up_dst),
    .up_last        (up_last),
    .tt_in_valid    (tt_in_valid),
    .tt_source      (tt_source),
    .tt_destination (tt_destination),
    .tt_out_valid   (tt_out_valid),
    .tt_cost        (tt_cost),
    .res_valid      (res_valid),
    .res_cost       (res_cost),
    .res_overflow   (res_overflow),
    .res_timeout    (res_timeout)
  );

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] fr[$];         // frame to send, {src,dst}
  logic [7:0] bq[$];         // captured burst, {source,destination}
  logic       first_rise;
  logic       ready_after;
  int         rdy_drop;

  // Sends fr[] with up to maxgap idle cycles before each pair. Starts and ends
  // just after a rising edge; on return the up_last handshake has just completed.
  task automatic send_frame(input int maxgap);
    rdy_drop = 0;
    for (int i = 0; i < fr.size(); i++) begin
      int g;
      g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      up_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      up_valid = 1'b1;
      up_src   = fr[i][7:4];
      up_dst   = fr[i][3:0];
      up_last  = (i == fr.size() - 1);
      @(negedge clk);
      if (up_ready !== 1'b1) rdy_drop++;
      @(posedge clk); #1;
    end
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  // Records the burst; returns at the falling edge of the first cycle after it.
  task automatic capture_burst();
    bq.delete();
    @(negedge clk);
    first_rise  = tt_in_valid;
    ready_after = up_ready;
    while (tt_in_valid && bq.size() < 100) begin
      bq.push_back({tt_source, tt_destination});
      @(negedge clk);
    end
  endtask

  // Engine model: result 'dly' cycles into WAIT; returns at falling edge of the
  // cycle where res_valid is expected.
  task automatic engine_respond(input int dly, input logic [3:0] cost);
    repeat (dly) @(negedge clk);
    tt_out_valid = 1'b1;
    tt_cost      = cost;
    @(negedge clk);
    tt_out_valid = 1'b0;
    tt_cost      = 4'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({up_ready, tt_in_valid, tt_source, tt_destination, res_valid, res_cost, res_overflow, res_timeout} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0})
      $display("FAIL reset_outputs: got rdy=%b iv=%b s=%0d d=%0d rv=%b c=%0d o=%b t=%b, want rdy=1 rest 0",
               up_ready, tt_in_valid, tt_source, tt_destination, res_valid, res_cost, res_overflow, res_timeout);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_path();
    logic [7:0] exp_b[$];
    exp_b = '{8'h03, 8'h01, 8'h12, 8'h23};
    fr = exp_b;
    send_frame(3);
    capture_burst();
    n_total++;
    if (first_rise !== 1'b1 || ready_after !== 1'b0)
      $display("FAIL basic_first_cycle: got in_valid=%b up_ready=%b, want 1 and 0", first_rise, ready_after);
    else n_pass++;
    n_total++;
    if (bq.size() !== 4) $display("FAIL basic_burst_len: got %0d want 4", bq.size());
    else n_pass++;
    n_total++;
    if (bq.size() != 4 || bq[0] !== exp_b[0] || bq[1] !== exp_b[1] || bq[2] !== exp_b[2] || bq[3] !== exp_b[3])
      $display("FAIL basic_burst_order: got %p want %p", bq, exp_b);
    else n_pass++;
    engine_respond(2, 4'd3);
    n_total++;
    if ({res_valid, res_cost, res_overflow, res_timeout, up_ready} !== {1'b1, 4'd3, 1'b0, 1'b0, 1'b0})
      $display("FAIL basic_result: got rv=%b c=%0d o=%b t=%b rdy=%b want rv=1 c=3 o=0 t=0 rdy=0",
               res_valid, res_cost, res_overflow, res_timeout, up_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (res_valid !== 1'b0 || up_ready !== 1'b1)
      $display("FAIL basic_after_result: got rv=%b rdy=%b want rv=0 rdy=1", res_valid, up_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_query_only();
    fr = '{8'h59};
    send_frame(0);
    capture_burst();
    n_total++;
    if (bq.size() !== 1 || bq[0] !== 8'h59)
      $display("FAIL query_burst: got len=%0d first=%h want len=1 first=59", bq.size(), (bq.size() > 0) ? bq[0] : 8'hxx);
    else n_pass++;
    engine_respond(0, 4'd0);
    n_total++;
    if ({res_valid, res_cost, res_timeout} !== {1'b1, 4'd0, 1'b0})
      $display("FAIL query_result: got rv=%b c=%0d t=%b want rv=1 c=0 t=0", res_valid, res_cost, res_timeout);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int bad;
    fr.delete();
    for (int i = 0; i < 40; i++) fr.push_back(8'(i));
    send_frame(1);
    n_total++;
    if (rdy_drop !== 0) $display("FAIL ovf_up_ready: got %0d not-ready cycles want 0", rdy_drop);
    else n_pass++;
    capture_burst();
    n_total++;
    if (bq.size() !== DEPTH) $display("FAIL ovf_burst_len: got %0d want %0d", bq.size(), DEPTH);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < bq.size(); i++) if (bq[i] !== 8'(i)) bad++;
    n_total++;
    if (bad !== 0) $display("FAIL ovf_burst_content: got %0d wrong entries want 0", bad);
    else n_pass++;
    engine_respond(1, 4'd5);
    n_total++;
    if ({res_valid, res_cost, res_overflow, res_timeout} !== {1'b1, 4'd5, 1'b1, 1'b0})
      $display("FAIL ovf_result: got rv=%b c=%0d o=%b t=%b want rv=1 c=5 o=1 t=0",
               res_valid, res_cost, res_overflow, res_timeout);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int k;
    fr = '{8'h12, 8'h34};
    send_frame(0);
    capture_burst();
    k = 0;
    while (!res_valid && k < 200) begin @(negedge clk); k++; end
    // Latency measured from the final burst cycle.
    n_total++;
    if (k + 1 !== TIMEOUT + 1) $display("FAIL timeout_latency: got %0d cycles want %0d", k + 1, TIMEOUT + 1);
    else n_pass++;
    n_total++;
    if ({res_valid, res_cost, res_timeout} !== {1'b1, 4'd0, 1'b1})
      $display("FAIL timeout_result: got rv=%b c=%0d t=%b want rv=1 c=0 t=1", res_valid, res_cost, res_timeout);
    else n_pass++;
    @(posedge clk); #1;
    // Next frame after a timeout
    fr = '{8'hAB, 8'hBC};
    send_frame(0);
    capture_burst();
    n_total++;
    if (bq.size() !== 2 || bq[0] !== 8'hAB || bq[1] !== 8'hBC)
      $display("FAIL after_timeout_burst: got %p want AB,BC", bq);
    else n_pass++;
    engine_respond(3, 4'd2);
    n_total++;
    if ({res_valid, res_cost, res_timeout} !== {1'b1, 4'd2, 1'b0})
      $display("FAIL after_timeout_result: got rv=%b c=%0d t=%b want rv=1 c=2 t=0", res_valid, res_cost, res_timeout);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    fr = '{8'h0F, 8'hF0};
    send_frame(0);
    capture_burst();
    engine_respond(TIMEOUT - 1, 4'd7);
    n_total++;
    if ({res_valid, res_cost, res_timeout} !== {1'b1, 4'd7, 1'b0})
      $display("FAIL collision_result: got rv=%b c=%0d t=%b want rv=1 c=7 t=0", res_valid, res_cost, res_timeout);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_emit();
    int spur;
    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(0);
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (tt_in_valid !== 1'b1) $display("FAIL rst_mid_in_burst: got in_valid=%b want 1", tt_in_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({up_ready, tt_in_valid, tt_source, tt_destination, res_valid, res_cost, res_overflow, res_timeout} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0})
      $display("FAIL rst_mid_outputs: got rdy=%b iv=%b s=%0d d=%0d rv=%b want rdy=1 rest 0",
               up_ready, tt_in_valid, tt_source, tt_destination, res_valid);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    for (int i = 0; i < TIMEOUT + 8; i++) begin
      @(negedge clk);
      if (res_valid || tt_in_valid || !up_ready) spur++;
    end
    n_total++;
    if (spur !== 0) $display("FAIL rst_mid_no_result: got %0d active cycles want 0", spur);
    else n_pass++;
    @(posedge clk); #1;
    fr = '{8'h47, 8'h45, 8'h57};
    send_frame(2);
    capture_burst();
    n_total++;
    if (bq.size() !== 3 || bq[0] !== 8'h47 || bq[1] !== 8'h45 || bq[2] !== 8'h57)
      $display("FAIL rst_mid_next_burst: got %p want 47,45,57", bq);
    else n_pass++;
    engine_respond(1, 4'd2);
    n_total++;
    if ({res_valid, res_cost, res_overflow, res_timeout} !== {1'b1, 4'd2, 1'b0, 1'b0})
      $display("FAIL rst_mid_next_result: got rv=%b c=%0d o=%b t=%b want rv=1 c=2 o=0 t=0",
               res_valid, res_cost, res_overflow, res_timeout);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic_path();
    test_query_only();
    test_overflow();
    test_timeout();
    test_collision();
    test_reset_mid_emit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
